// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-controller bus: ID-stage instruction fields and EX redirect in,
// pipeline stall/flush/bubble controls and EX forwarding selects out.
interface pipe_hazard_ctrl_if #(
    parameter int RF_ADDRESS = 5,
    parameter int FWD_W      = 2,
    parameter int CNT_W      = 32
);
    logic                  id_valid;
    logic [RF_ADDRESS-1:0] id_rs1;
    logic [RF_ADDRESS-1:0] id_rs2;
    logic [RF_ADDRESS-1:0] id_rd;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  id_mc;
    logic                  ex_redirect;
    logic                  stall_if;
    logic                  stall_id;
    logic                  flush_ifid;
    logic                  bubble_idex;
    logic                  mc_busy;
    logic [FWD_W-1:0]      fwd_a_sel;
    logic [FWD_W-1:0]      fwd_b_sel;
    logic [CNT_W-1:0]      stall_cnt;

    modport master (
        output id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_mc, ex_redirect,
        input  stall_if, stall_id, flush_ifid, bubble_idex, mc_busy, fwd_a_sel, fwd_b_sel, stall_cnt
    );

    modport slave (
        input  id_valid, id_rs1, id_rs2, id_rd, id_regwrite, id_memread, id_mc, ex_redirect,
        output stall_if, stall_id, flush_ifid, bubble_idex, mc_busy, fwd_a_sel, fwd_b_sel, stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Purpose: hazard tracking, EX operand forwarding and stall/flush/bubble control for the in-order pipeline.
// Latency: all control outputs combinational in the current cycle; tracker state advances on the next edge.
// Backpressure: load-use and multi-cycle EX occupancy hold PC and IF/ID; a taken EX redirect flushes instead.
module pipe_hazard_ctrl #(
    parameter int RF_ADDRESS = 5,
    parameter int DEPTH      = 4,
    parameter int MC_LAT     = 4,
    parameter int FWD_W      = $clog2(DEPTH-1),
    parameter int CNT_W      = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              init_load,
    pipe_hazard_ctrl_if.slave hz
);
    localparam int             MCW     = $clog2(MC_LAT) + 1;
    localparam logic [MCW-1:0] MC_LOAD = MCW'(MC_LAT - 1);

    typedef struct packed {
        logic                  valid;
        logic [RF_ADDRESS-1:0] rd;
        logic                  regwrite;
        logic                  memread;
        logic [RF_ADDRESS-1:0] rs1;
        logic [RF_ADDRESS-1:0] rs2;
    } ent_t;

    ent_t             ent_q [1:DEPTH-1];
    ent_t             ent_d [1:DEPTH-1];
    logic [MCW-1:0]   mc_cnt_q, mc_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic             clr, busy, lu, redir, stall, bubble, accept;
    logic [FWD_W-1:0] fwd_a, fwd_b;

    always_comb begin
        clr    = ~reset | init_load;
        busy   = (mc_cnt_q != '0);
        lu     = hz.id_valid && ent_q[1].valid && ent_q[1].memread && (ent_q[1].rd != '0) &&
                 ((ent_q[1].rd == hz.id_rs1) || (ent_q[1].rd == hz.id_rs2));
        // A redirect while EX is occupied by a multi-cycle op cannot be real; drop it.
        redir  = hz.ex_redirect & ~busy;
        stall  = (lu | busy) & ~redir;
        bubble = lu | redir;
        accept = hz.id_valid & ~bubble & ~busy;
    end

    // Scan oldest to youngest so the youngest matching producer wins.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = DEPTH - 1; k >= 2; k--) begin
            if (ent_q[k].valid && ent_q[k].regwrite && (ent_q[k].rd != '0)) begin
                if (ent_q[k].rd == ent_q[1].rs1) fwd_a = FWD_W'(k - 1);
                if (ent_q[k].rd == ent_q[1].rs2) fwd_b = FWD_W'(k - 1);
            end
        end
    end

    always_comb begin
        ent_d[1] = '0;
        for (int k = 2; k < DEPTH; k++) ent_d[k] = ent_q[k-1];
        if (accept) begin
            ent_d[1].valid    = 1'b1;
            ent_d[1].rd       = hz.id_rd;
            ent_d[1].regwrite = hz.id_regwrite;
            ent_d[1].memread  = hz.id_memread;
            ent_d[1].rs1      = hz.id_rs1;
            ent_d[1].rs2      = hz.id_rs2;
        end
        if (busy) begin
            ent_d[1] = ent_q[1];
            ent_d[2] = '0;
        end

        mc_cnt_d = mc_cnt_q;
        if (busy) mc_cnt_d = mc_cnt_q - MCW'(1);
        else if (accept && hz.id_mc) mc_cnt_d = MC_LOAD;

        stall_cnt_d = stall_cnt_q;
        if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset || init_load) begin
            for (int k = 1; k < DEPTH; k++) ent_q[k] <= '0;
            mc_cnt_q    <= '0;
            stall_cnt_q <= '0;
        end else begin
            ent_q       <= ent_d;
            mc_cnt_q    <= mc_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_if    = stall & ~clr;
    assign hz.stall_id    = stall & ~clr;
    assign hz.flush_ifid  = redir & ~clr;
    assign hz.bubble_idex = bubble & ~clr;
    assign hz.mc_busy     = busy & ~clr;
    assign hz.fwd_a_sel   = clr ? '0 : fwd_a;
    assign hz.fwd_b_sel   = clr ? '0 : fwd_b;
    assign hz.stall_cnt   = clr ? '0 : stall_cnt_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench: directed instruction sequences push per-cycle expected controls; a negedge monitor compares.
module tb_pipe_hazard_ctrl;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic init_load = 1'b0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if #(.RF_ADDRESS(5), .FWD_W(2), .CNT_W(32)) bus1 ();
    pipe_hazard_ctrl_if #(.RF_ADDRESS(5), .FWD_W(2), .CNT_W(32)) bus2 ();

    pipe_hazard_ctrl #(.RF_ADDRESS(5), .DEPTH(4), .MC_LAT(4), .CNT_W(32)) dut1 (
        .clk(clk), .reset(reset), .init_load(init_load), .hz(bus1.slave)
    );
    pipe_hazard_ctrl #(.RF_ADDRESS(5), .DEPTH(4), .MC_LAT(1), .CNT_W(32)) dut2 (
        .clk(clk), .reset(reset), .init_load(init_load), .hz(bus2.slave)
    );

    typedef struct {
        string       nm;
        bit          d2;
        logic [40:0] v;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    logic [40:0] act1, act2;
    assign act1 = {bus1.stall_if, bus1.stall_id, bus1.flush_ifid, bus1.bubble_idex, bus1.mc_busy,
                   bus1.fwd_a_sel, bus1.fwd_b_sel, bus1.stall_cnt};
    assign act2 = {bus2.stall_if, bus2.stall_id, bus2.flush_ifid, bus2.bubble_idex, bus2.mc_busy,
                   bus2.fwd_a_sel, bus2.fwd_b_sel, bus2.stall_cnt};

    always @(negedge clk) begin
        if (sb_q.size() > 0) begin
            exp_t        e;
            logic [40:0] a;
            e = sb_q.pop_front();
            a = e.d2 ? act2 : act1;
            checks++;
            if (a !== e.v) begin
                failures++;
                $display("FAIL %s: got {stif,stid,fl,bu,busy,fa,fb,cnt}=%b_%b_%b_%b_%b_%0d_%0d_%0d required %b_%b_%b_%b_%b_%0d_%0d_%0d",
                         e.nm, a[40], a[39], a[38], a[37], a[36], a[35:34], a[33:32], a[31:0],
                         e.v[40], e.v[39], e.v[38], e.v[37], e.v[36], e.v[35:34], e.v[33:32], e.v[31:0]);
            end
        end
    end

    always @(negedge clk) begin
        assert (!(bus1.ex_redirect && bus1.mc_busy)) else $error("illegal ex_redirect while mc_busy (dut1)");
        assert (!(bus2.ex_redirect && bus2.mc_busy)) else $error("illegal ex_redirect while mc_busy (dut2)");
    end

    task automatic idle_all();
        bus1.id_valid = 0; bus1.id_rs1 = 0; bus1.id_rs2 = 0; bus1.id_rd = 0;
        bus1.id_regwrite = 0; bus1.id_memread = 0; bus1.id_mc = 0; bus1.ex_redirect = 0;
        bus2.id_valid = 0; bus2.id_rs1 = 0; bus2.id_rs2 = 0; bus2.id_rd = 0;
        bus2.id_regwrite = 0; bus2.id_memread = 0; bus2.id_mc = 0; bus2.ex_redirect = 0;
    endtask

    // One cycle: drive reset/init_load and one ID instruction to the selected DUT, queue the expected controls.
    task automatic step(input string nm, input bit d2, input bit rst_n, input bit il,
                        input bit v, input int rs1, input int rs2, input int rd,
                        input bit rw, input bit mr, input bit mc, input bit rdr,
                        input bit e_st, input bit e_bu, input bit e_fl, input bit e_busy,
                        input int e_fa, input int e_fb, input int e_cnt);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = rst_n;
        init_load = il;
        idle_all();
        if (d2) begin
            bus2.id_valid = v; bus2.id_rs1 = 5'(rs1); bus2.id_rs2 = 5'(rs2); bus2.id_rd = 5'(rd);
            bus2.id_regwrite = rw; bus2.id_memread = mr; bus2.id_mc = mc; bus2.ex_redirect = rdr;
        end else begin
            bus1.id_valid = v; bus1.id_rs1 = 5'(rs1); bus1.id_rs2 = 5'(rs2); bus1.id_rd = 5'(rd);
            bus1.id_regwrite = rw; bus1.id_memread = mr; bus1.id_mc = mc; bus1.ex_redirect = rdr;
        end
        e.nm = nm;
        e.d2 = d2;
        e.v  = {e_st, e_st, e_fl, e_bu, e_busy, 2'(e_fa), 2'(e_fb), 32'(e_cnt)};
        sb_q.push_back(e);
    endtask

    task automatic rst_rand(input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        reset     = 1'b0;
        init_load = 1'b0;
        idle_all();
        bus1.id_valid = 1'($urandom); bus1.id_rs1 = 5'($urandom); bus1.id_rs2 = 5'($urandom);
        bus1.id_rd = 5'($urandom); bus1.id_regwrite = 1'($urandom); bus1.id_memread = 1'($urandom);
        bus1.id_mc = 1'($urandom); bus1.ex_redirect = 1'($urandom);
        e.nm = nm;
        e.d2 = 1'b0;
        e.v  = '0;
        sb_q.push_back(e);
    endtask

    initial begin
        idle_all();
        rst_rand("rst_rand0");
        rst_rand("rst_rand1");
        step("post_rst",  0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        // add x5,x1,x2 ; sub x6,x5,x3 back to back
        step("fwd1_add",  0, 1, 0,  1, 1, 2, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("fwd1_sub",  0, 1, 0,  1, 5, 3, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("fwd1_ex",   0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
        // same pair with an independent or x11,x12,x13 between
        step("fwd2_add",  0, 1, 0,  1, 1, 2, 5, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("fwd2_or",   0, 1, 0,  1, 12, 13, 11, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("fwd2_sub",  0, 1, 0,  1, 5, 3, 6, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("fwd2_ex",   0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 0);
        step("fwd2_idle", 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        // lw x7,0(x1) ; add x8,x2,x7
        step("lu_lw",     0, 1, 0,  1, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("lu_stall",  0, 1, 0,  1, 2, 7, 8, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 0);
        step("lu_retry",  0, 1, 0,  1, 2, 7, 8, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 1);
        step("lu_fwd",    0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 1);
        // multi-cycle op x9 ; add x10,x9,x0
        step("mc_issue",  0, 1, 0,  1, 3, 4, 9, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 1);
        step("mc_busy1",  0, 1, 0,  1, 9, 0, 10, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 1);
        step("mc_busy2",  0, 1, 0,  1, 9, 0, 10, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 2);
        step("mc_busy3",  0, 1, 0,  1, 9, 0, 10, 1, 0, 0, 0,  1, 0, 0, 1, 0, 0, 3);
        step("mc_done",   0, 1, 0,  1, 9, 0, 10, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("mc_fwd",    0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 4);
        // load-use coinciding with a taken redirect
        step("rd_lw",     0, 1, 0,  1, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("rd_flush",  0, 1, 0,  1, 2, 7, 8, 1, 0, 0, 1,  0, 1, 1, 0, 0, 0, 4);
        step("rd_after",  0, 1, 0,  1, 2, 7, 8, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("rd_fwd",    0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 2, 4);
        // x0 writers and loads never forward or stall
        step("x0_wr",     0, 1, 0,  1, 1, 2, 0, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("x0_rd",     0, 1, 0,  1, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("x0_fwd",    0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("x0_lw",     0, 1, 0,  1, 1, 0, 0, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("x0_lu",     0, 1, 0,  1, 0, 0, 3, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("x0_lu_fwd", 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        // load-use through rs1
        step("lu1_lw",    0, 1, 0,  1, 1, 0, 7, 1, 1, 0, 0,  0, 0, 0, 0, 0, 0, 4);
        step("lu1_stall", 0, 1, 0,  1, 7, 2, 8, 1, 0, 0, 0,  1, 1, 0, 0, 0, 0, 4);
        step("lu1_retry", 0, 1, 0,  1, 7, 2, 8, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 5);
        step("lu1_fwd",   0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 2, 0, 5);
        // reset, then init_load, in the middle of a multi-cycle op
        step("mcr_issue", 0, 1, 0,  1, 3, 4, 9, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 5);
        step("mcr_busy",  0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 5);
        step("mcr_reset", 0, 0, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("mcr_after", 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("mci_issue", 0, 1, 0,  1, 3, 4, 9, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        step("mci_busy",  0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  1, 0, 0, 1, 0, 0, 0);
        step("mci_init",  0, 1, 1,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("mci_after", 0, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        // MC_LAT=1 instance: multi-cycle op costs no stall
        step("lat1_mc",   1, 1, 0,  1, 3, 4, 9, 1, 0, 1, 0,  0, 0, 0, 0, 0, 0, 0);
        step("lat1_add",  1, 1, 0,  1, 9, 0, 10, 1, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
        step("lat1_fwd",  1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 1, 0, 0);
        step("lat1_idle", 1, 1, 0,  0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);

        repeat (3) @(posedge clk);
        if (sb_q.size() != 0) begin
            failures++;
            $display("FAIL sb_drain: %0d expectations left unchecked, required 0", sb_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
